// File: rtl/filter_pkg.sv
// filter_pkg: shared controller state encoding and default frame geometry.
package filter_pkg;
    localparam int DEF_H_RES = 170;
    localparam int DEF_V_RES = 240;
    typedef enum logic [2:0] {IDLE, FEED, HBLANK, FLUSH, DRAIN, DONE} state_t;
endpackage

// File: rtl/filter_line_timer.sv
// filter_line_timer: column, blank and line counters with line-end and blank-end strobes.
module filter_line_timer #(
    parameter int H_RES   = 170,
    parameter int H_BLANK = 16,
    parameter int LINES   = 243
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         act,
    input  logic                         blk,
    output logic [$clog2(H_RES+1)-1:0]   col,
    output logic [$clog2(LINES+1)-1:0]   line,
    output logic                         line_end,
    output logic                         blank_end
);
    localparam int CW = $clog2(H_RES+1);
    localparam int BW = $clog2(H_BLANK+1);
    logic [BW-1:0] bcnt;
    assign line_end  = act && col == CW'(H_RES-1);
    assign blank_end = blk && bcnt == BW'(H_BLANK-1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col  <= '0;
            bcnt <= '0;
            line <= '0;
        end else if (clr) begin
            col  <= '0;
            bcnt <= '0;
            line <= '0;
        end else begin
            if (act) col <= line_end ? '0 : col + 1'b1;
            if (blk) bcnt <= blank_end ? '0 : bcnt + 1'b1;
            if (line_end) line <= line + 1'b1;
        end
    end
endmodule

// File: rtl/filter_frame_ctrl.sv
// filter_frame_ctrl: sequences one frame of reads, zero-filled flush lines and result writes.
// Macro FILTER_CTRL_TIMEOUT_EN adds a DRAIN timeout (TIMEOUT_CYC) that forces DONE and sets o_timeout.
module filter_frame_ctrl
    import filter_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int H_BLANK     = 16,
    parameter int FLUSH_LINES = 3,
    parameter int ADDR_W      = 17
`ifdef FILTER_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_de,
    output logic              o_zero_fill,
    input  logic              i_f_de,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_timeout
);
    localparam int LINES = V_RES + FLUSH_LINES;
    localparam int TOTAL = H_RES * V_RES;
    localparam int OW    = $clog2(TOTAL+1);
    localparam int CW    = $clog2(H_RES+1);
    localparam int LW    = $clog2(LINES+1);
    state_t state, state_nx;
    logic [CW-1:0] col;
    logic [LW-1:0] line;
    logic [OW-1:0] ocnt;
    logic line_end, blank_end, run, reached, tmo_hit, de_q, zf_q;

    assign run     = state inside {FEED, HBLANK, FLUSH, DRAIN};
    assign reached = ocnt == OW'(TOTAL);

    // Flush lines reuse the HBLANK state for their gaps; the line count tells them apart.
    filter_line_timer #(.H_RES(H_RES), .H_BLANK(H_BLANK), .LINES(LINES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (state == IDLE),
        .act       (state == FEED || state == FLUSH),
        .blk       (state == HBLANK),
        .col       (col),
        .line      (line),
        .line_end  (line_end),
        .blank_end (blank_end)
    );

`ifdef FILTER_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC+1);
    logic [TW-1:0] tcnt;
    logic tmo;
    assign tmo_hit   = state == DRAIN && !reached && tcnt == TW'(TIMEOUT_CYC-1);
    assign o_timeout = tmo;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
            tmo  <= 1'b0;
        end else begin
            tcnt <= state == DRAIN ? tcnt + 1'b1 : '0;
            if (state == IDLE && i_start) tmo <= 1'b0;
            else if (tmo_hit) tmo <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = FEED;
            FEED:    if (line_end) state_nx = HBLANK;
            HBLANK:  if (blank_end) state_nx = line < LW'(V_RES) ? FEED : FLUSH;
            FLUSH:   if (line_end) state_nx = line == LW'(LINES-1) ? DRAIN : HBLANK;
            DRAIN:   if (reached || tmo_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = run;
        o_done      = state == DONE;
        o_rd_en     = state == FEED;
        o_rd_addr   = o_rd_en ? ADDR_W'(line) * ADDR_W'(H_RES) + ADDR_W'(col) : '0;
        o_de        = de_q;
        o_zero_fill = zf_q;
        o_wr_en     = i_f_de && run && !reached;
        o_wr_addr   = o_wr_en ? ADDR_W'(ocnt) : '0;
    end

    // de/zero_fill lag the feed by one cycle to match the source buffer read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q <= 1'b0;
            zf_q <= 1'b0;
            ocnt <= '0;
        end else begin
            de_q <= state == FEED || state == FLUSH;
            zf_q <= state == FLUSH;
            if (state == IDLE) ocnt <= '0;
            else if (o_wr_en) ocnt <= ocnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_filter_frame_ctrl.sv
// tb_filter_frame_ctrl: randomized bench; a cycle-indexed frame model predicts every DUT output.
module tb_filter_frame_ctrl;
    localparam int H_RES = 4, V_RES = 3, H_BLANK = 2, FLUSH_LINES = 1, ADDR_W = 17;
    localparam int P     = H_RES + H_BLANK;
    localparam int TOTAL = H_RES * V_RES;
    localparam int D0    = (V_RES + FLUSH_LINES - 1) * P + H_RES;
`ifdef FILTER_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    localparam int TCYC   = 20;
`else
    localparam bit TMO_EN = 1'b0;
    localparam int TCYC   = 0;
`endif
    logic clk = 1'b0, reset = 1'b1, i_start = 1'b0, i_f_de = 1'b0;
    logic o_busy, o_done, o_rd_en, o_de, o_zero_fill, o_wr_en, o_timeout;
    logic [ADDR_W-1:0] o_rd_addr, o_wr_addr;
    int checks = 0, errors = 0;
    int m_n = -1, m_done_at = -1, m_cnt = 0;
    bit m_tmo = 1'b0;
    int rd_idx, wr_idx, zf_cnt, zf_bad, done_cnt, busy_cnt;
    int dly = 1, keep = 999, passed = 0;
    bit noise = 1'b0;
    bit hist[$];

    filter_frame_ctrl #(
        .H_RES(H_RES), .V_RES(V_RES), .H_BLANK(H_BLANK), .FLUSH_LINES(FLUSH_LINES), .ADDR_W(ADDR_W)
`ifdef FILTER_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYC(TCYC)
`endif
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_de(o_de), .o_zero_fill(o_zero_fill),
        .i_f_de(i_f_de), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // m = cycles since the start was accepted
    function automatic bit is_feed(int m);
        return m >= 0 && m < V_RES * P && m % P < H_RES;
    endfunction
    function automatic bit is_flush(int m);
        return m >= V_RES * P && m < D0 && (m - V_RES * P) % P < H_RES;
    endfunction

    always @(negedge clk) begin
        bit e_busy, e_wr;
        if (reset) begin
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_rd_en", o_rd_en, 0);
            chk("rst_rd_addr", o_rd_addr, 0);
            chk("rst_de", o_de, 0);
            chk("rst_zero_fill", o_zero_fill, 0);
            chk("rst_wr_en", o_wr_en, 0);
            chk("rst_wr_addr", o_wr_addr, 0);
            chk("rst_timeout", o_timeout, 0);
            m_n = -1;
            m_done_at = -1;
            m_cnt = 0;
            m_tmo = 1'b0;
        end else begin
            e_busy = m_n >= 0 && (m_done_at < 0 || m_n < m_done_at);
            e_wr = i_f_de && e_busy && m_cnt < TOTAL;
            chk("busy", o_busy, e_busy);
            chk("done", o_done, m_n >= 0 && m_n == m_done_at);
            chk("rd_en", o_rd_en, is_feed(m_n));
            chk("rd_addr", o_rd_addr, is_feed(m_n) ? (m_n / P) * H_RES + m_n % P : 0);
            chk("de", o_de, m_n >= 1 && (is_feed(m_n - 1) || is_flush(m_n - 1)));
            chk("zero_fill", o_zero_fill, m_n >= 1 && is_flush(m_n - 1));
            chk("wr_en", o_wr_en, e_wr);
            chk("wr_addr", o_wr_addr, e_wr ? m_cnt : 0);
            chk("timeout", o_timeout, m_tmo);
            if (o_rd_en) begin
                chk("rd_seq", o_rd_addr, rd_idx);
                rd_idx++;
            end
            if (o_wr_en) begin
                chk("wr_seq", o_wr_addr, wr_idx);
                wr_idx++;
            end
            if (o_zero_fill) begin
                zf_cnt++;
                if (!o_de || o_rd_en) zf_bad++;
            end
            if (o_done) done_cnt++;
            if (o_busy) busy_cnt++;
            if (e_busy && m_n >= D0 && m_done_at < 0) begin
                if (m_cnt == TOTAL) m_done_at = m_n + 1;
                else if (TMO_EN && m_n - D0 == TCYC - 1) begin
                    m_done_at = m_n + 1;
                    m_tmo = 1'b1;
                end
            end
            if (e_wr) m_cnt++;
            if (m_n < 0) begin
                if (i_start) begin
                    m_n = 0;
                    m_done_at = -1;
                    m_cnt = 0;
                    m_tmo = 1'b0;
                end
            end else if (m_n == m_done_at) m_n = -1;
            else m_n++;
        end
    end

    // chain model: o_de delayed by dly, first keep pulses passed, optional random noise pulses
    task automatic step();
        @(posedge clk);
        #1;
        hist.push_front(o_de);
        i_f_de = 1'b0;
        if (!reset && hist.size() > dly && hist[dly] && passed < keep) begin
            i_f_de = 1'b1;
            passed++;
        end
        if (noise && $urandom_range(0, 7) == 0) i_f_de = 1'b1;
        if (reset) hist.delete();
        if (hist.size() > 40) void'(hist.pop_back());
    endtask

    task automatic run_frame(input int d, input int k, input bit nz, input bit mid, input int stop_at);
        dly = d;
        keep = k;
        noise = nz;
        passed = 0;
        hist.delete();
        rd_idx = 0;
        wr_idx = 0;
        zf_cnt = 0;
        zf_bad = 0;
        done_cnt = 0;
        busy_cnt = 0;
        i_start = 1'b1;
        step();
        for (int c = 0; c < 3000; c++) begin
            i_start = 1'b0;
            if (m_n < 0 || m_n == stop_at) break;
            if (mid && (m_n == 2 || $urandom_range(0, 9) == 0)) i_start = 1'b1;
            step();
        end
        i_start = 1'b0;
        chk("frame_end_reached", m_n < 0 || m_n == stop_at, 1);
    endtask

    initial begin
        repeat (3) step();
        chk("reset_busy_literal", o_busy, 0);
        reset = 1'b0;
        repeat (2) step();
        run_frame(10, 999, 0, 0, -1);
        chk("s1_rd_cnt", rd_idx, 12);
        chk("s1_wr_cnt", wr_idx, 12);
        chk("s1_zf_cnt", zf_cnt, 4);
        chk("s1_zf_align", zf_bad, 0);
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_busy_cycles", busy_cnt, 28);
        repeat (2) step();
        run_frame(2, 999, 0, 0, -1);
        chk("s2_wr_cnt", wr_idx, 12);
        chk("s2_done_cnt", done_cnt, 1);
        chk("s2_busy_cycles", busy_cnt, 23);
        repeat (2) step();
        run_frame(10, 999, 0, 1, -1);
        chk("s3_rd_cnt", rd_idx, 12);
        chk("s3_done_cnt", done_cnt, 1);
        repeat (2) step();
        run_frame(10, 999, 0, 0, 10);
        reset = 1'b1;
        repeat (3) step();
        chk("s4_no_done", done_cnt, 0);
        reset = 1'b0;
        repeat (2) step();
        run_frame(10, 999, 0, 0, -1);
        chk("s4_rd_cnt", rd_idx, 12);
        chk("s4_done_cnt", done_cnt, 1);
`ifdef FILTER_CTRL_TIMEOUT_EN
        repeat (2) step();
        run_frame(3, 5, 0, 0, -1);
        chk("s5_wr_cnt", wr_idx, 5);
        chk("s5_busy_cycles", busy_cnt, D0 + TCYC);
        chk("s5_done_cnt", done_cnt, 1);
        chk("s5_tmo_set", o_timeout, 1);
        step();
        run_frame(10, 999, 0, 0, -1);
        chk("s5_tmo_clr", o_timeout, 0);
`endif
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(1, 4)) step();
            run_frame($urandom_range(1, 20), (TMO_EN && $urandom_range(0, 1) == 1) ? 5 : 999,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
